// File: rtl/instr_encoder_loader_if.sv
// rtl/instr_encoder_loader_if.sv - request handshake and instruction-memory write bus
interface instr_encoder_loader_if #(
  parameter int ADDR_W = 6
);
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_class;
  logic [2:0]        req_alu;
  logic [4:0]        req_rd;
  logic [4:0]        req_rs1;
  logic [4:0]        req_rs2;
  logic [11:0]       req_imm;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output req_valid, req_class, req_alu, req_rd, req_rs1, req_rs2, req_imm,
    input  req_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  req_valid, req_class, req_alu, req_rd, req_rs1, req_rs2, req_imm,
    output req_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// rtl/instr_encoder_loader.sv - RV32I micro-op encoder and sequential instruction-memory loader
// Define ENCODER_CHECKSUM_EN to keep a running XOR of every written word.
module instr_encoder_loader #(
  parameter int ADDR_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  instr_encoder_loader_if.slave bus,
  input  logic                  flush,
  output logic                  full,
  output logic                  err,
  output logic [ADDR_W:0]       count,
  output logic [31:0]           checksum
);
  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(1) << ADDR_W;

  typedef enum logic [1:0] {IDLE, ENCODE, WRITE} state_t;

  state_t            state, state_nxt;
  logic              ready, we, accept, do_flush, do_load, do_err;
  logic [2:0]        cls_q, alu_q;
  logic [4:0]        rd_q, rs1_q, rs2_q;
  logic [11:0]       imm_q;
  logic [ADDR_W-1:0] ptr_q, addr_q;
  logic [ADDR_W:0]   count_q;
  logic [31:0]       word_q, word_c;
  logic              err_q, legal, alu_ok;
  logic [2:0]        f3;
  logic [6:0]        f7;

  // funct3/funct7 chosen so the core's ALU decoder maps back to the same ALUControl
  always_comb begin
    alu_ok = 1'b1;
    f3     = 3'b000;
    case (alu_q)
      3'b000, 3'b001: f3 = 3'b000;
      3'b010:         f3 = 3'b111;
      3'b011:         f3 = 3'b110;
      3'b101:         f3 = 3'b010;
      default:        alu_ok = 1'b0;
    endcase
    f7     = (alu_q == 3'b001) ? 7'b0100000 : 7'b0000000;
    legal  = 1'b1;
    word_c = '0;
    case (cls_q)
      3'b000: begin
        legal  = alu_ok;
        word_c = {f7, rs2_q, rs1_q, f3, rd_q, 7'b0110011};
      end
      3'b001: begin
        legal  = alu_ok && (alu_q != 3'b001);
        word_c = {imm_q, rs1_q, f3, rd_q, 7'b0010011};
      end
      3'b010: word_c = {imm_q, rs1_q, 3'b010, rd_q, 7'b0000011};
      3'b011: word_c = {imm_q[11:5], rs2_q, rs1_q, 3'b010, imm_q[4:0], 7'b0100011};
      3'b100: word_c = {imm_q[11], imm_q[9:4], rs2_q, rs1_q, 3'b000,
                        imm_q[3:0], imm_q[10], 7'b1100011};
      default: legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    we        = 1'b0;
    accept    = 1'b0;
    do_flush  = 1'b0;
    do_load   = 1'b0;
    do_err    = 1'b0;
    case (state)
      IDLE: begin
        ready = !full;
        if (flush) begin
          do_flush = 1'b1;
        end else if (bus.req_valid && !full) begin
          accept    = 1'b1;
          state_nxt = ENCODE;
        end
      end
      ENCODE: begin
        if (legal) begin
          do_load   = 1'b1;
          state_nxt = WRITE;
        end else begin
          do_err    = 1'b1;
          state_nxt = IDLE;
        end
      end
      WRITE: begin
        we        = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // addr/wdata are loaded only when a legal word is staged, so they hold between strobes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cls_q   <= '0;
      alu_q   <= '0;
      rd_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      imm_q   <= '0;
      ptr_q   <= '0;
      addr_q  <= '0;
      word_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        cls_q <= bus.req_class;
        alu_q <= bus.req_alu;
        rd_q  <= bus.req_rd;
        rs1_q <= bus.req_rs1;
        rs2_q <= bus.req_rs2;
        imm_q <= bus.req_imm;
      end
      if (do_load) begin
        word_q <= word_c;
        addr_q <= ptr_q;
      end
      if (do_err) err_q <= 1'b1;
      if (we) begin
        ptr_q   <= ptr_q + ADDR_W'(1);
        count_q <= count_q + (ADDR_W+1)'(1);
      end
      if (do_flush) begin
        ptr_q   <= '0;
        count_q <= '0;
        err_q   <= 1'b0;
      end
    end
  end

`ifdef ENCODER_CHECKSUM_EN
  logic [31:0] cksum_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          cksum_q <= '0;
    else if (do_flush) cksum_q <= '0;
    else if (we)       cksum_q <= cksum_q ^ word_q;
  end

  assign checksum = cksum_q;
`else
  assign checksum = '0;
`endif

  assign full           = (count_q == DEPTH);
  assign err            = err_q;
  assign count          = count_q;
  assign bus.req_ready  = ready;
  assign bus.imem_we    = we;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = word_q;
endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb/tb_instr_encoder_loader.sv - directed bench with a transaction-level encoder/loader model
module tb_instr_encoder_loader;
  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          full, err;
  logic [AW:0]   count;
  logic [31:0]   checksum;

  instr_encoder_loader_if #(.ADDR_W(AW)) bus ();

  instr_encoder_loader #(.ADDR_W(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .flush    (flush),
    .full     (full),
    .err      (err),
    .count    (count),
    .checksum (checksum)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  int          stage = 0;
  bit          hs = 1'b0;
  bit          p_legal = 1'b0;
  logic [31:0] p_word = '0;
  int          m_ptr = 0;
  int          m_count = 0;
  bit          m_err = 1'b0;
  logic [31:0] m_ck = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Standard RV32I field packing; branch offset is rebuilt as a 13-bit byte offset
  function automatic logic [32:0] model_enc(input logic [2:0] c, input logic [2:0] a,
                                            input logic [4:0] rd, input logic [4:0] rs1,
                                            input logic [4:0] rs2, input logic [11:0] imm);
    int          f3;
    bit          aok;
    logic [31:0] w;
    logic [12:0] off;
    aok = 1'b1;
    f3  = 0;
    case (a)
      3'd0, 3'd1: f3 = 0;
      3'd2:       f3 = 7;
      3'd3:       f3 = 6;
      3'd5:       f3 = 2;
      default:    aok = 1'b0;
    endcase
    off = {imm, 1'b0};
    w   = 32'(rs1) << 15;
    case (c)
      3'd0: return {aok, w | 32'h33 | 32'(rd) << 7 | 32'(f3) << 12 | 32'(rs2) << 20
                    | ((a == 3'd1) ? 32'h4000_0000 : 32'h0)};
      3'd1: return {aok && (a != 3'd1), w | 32'h13 | 32'(rd) << 7 | 32'(f3) << 12 | 32'(imm) << 20};
      3'd2: return {1'b1, w | 32'h03 | 32'(rd) << 7 | 32'(2) << 12 | 32'(imm) << 20};
      3'd3: return {1'b1, w | 32'h23 | (32'(imm) & 32'h1F) << 7 | 32'(2) << 12
                    | 32'(rs2) << 20 | (32'(imm) >> 5) << 25};
      3'd4: return {1'b1, w | 32'h63 | 32'(off[11]) << 7 | 32'(off[4:1]) << 8
                    | 32'(rs2) << 20 | 32'(off[10:5]) << 25 | 32'(off[12]) << 31};
      default: return {1'b0, 32'h0};
    endcase
  endfunction

  // Checks every output at the negedge, then advances the model past the coming edge
  task automatic model_compare();
    bit          full_exp, ready_exp;
    logic [32:0] e;
    hs = 1'b0;
    if (!rst) begin
      stage = 0; m_ptr = 0; m_count = 0; m_err = 1'b0; m_ck = '0;
      chk("rst_we", 32'(bus.imem_we), 32'd0);
      chk("rst_ready", 32'(bus.req_ready), 32'd1);
      chk("rst_count", 32'(count), 32'd0);
      return;
    end
    full_exp  = (m_count == DEPTH);
    ready_exp = (stage == 0) && !full_exp;
    chk("req_ready", 32'(bus.req_ready), 32'(ready_exp));
    chk("imem_we", 32'(bus.imem_we), 32'(stage == 2));
    if (stage == 2) begin
      chk("imem_addr", 32'(bus.imem_addr), 32'(m_ptr));
      chk("imem_wdata", bus.imem_wdata, p_word);
    end
    chk("count", 32'(count), 32'(m_count));
    chk("err", 32'(err), 32'(m_err));
    chk("full", 32'(full), 32'(full_exp));
    chk("checksum", checksum, m_ck);
    case (stage)
      2: begin
        m_ptr   = (m_ptr + 1) % DEPTH;
        m_count = m_count + 1;
`ifdef ENCODER_CHECKSUM_EN
        m_ck    = m_ck ^ p_word;
`endif
        stage   = 0;
      end
      1: begin
        if (p_legal) stage = 2;
        else begin m_err = 1'b1; stage = 0; end
      end
      default: begin
        if (flush) begin
          m_ptr = 0; m_count = 0; m_err = 1'b0; m_ck = '0;
        end else if (bus.req_valid && ready_exp) begin
          e = model_enc(bus.req_class, bus.req_alu, bus.req_rd, bus.req_rs1, bus.req_rs2, bus.req_imm);
          p_legal = e[32];
          p_word  = e[31:0];
          hs      = 1'b1;
          stage   = 1;
        end
      end
    endcase
  endtask

  task automatic tick();
    @(negedge clk);
    model_compare();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] c, input logic [2:0] a, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [11:0] imm);
    int n;
    bus.req_class = c; bus.req_alu = a; bus.req_rd = rd;
    bus.req_rs1 = rs1; bus.req_rs2 = rs2; bus.req_imm = imm;
    bus.req_valid = 1'b1;
    n = 0;
    while (!hs && n < 20) begin tick(); n++; end
    bus.req_valid = 1'b0;
    chk("accept_timeout", 32'(hs), 32'd1);
    n = 0;
    while (stage != 0 && n < 10) begin tick(); n++; end
    chk("done_timeout", 32'(stage == 0), 32'd1);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic reset_lits();
    chk("lit_rst_ready", 32'(bus.req_ready), 32'd1);
    chk("lit_rst_we", 32'(bus.imem_we), 32'd0);
    chk("lit_rst_addr", 32'(bus.imem_addr), 32'd0);
    chk("lit_rst_wdata", bus.imem_wdata, 32'd0);
    chk("lit_rst_full", 32'(full), 32'd0);
    chk("lit_rst_err", 32'(err), 32'd0);
    chk("lit_rst_count", 32'(count), 32'd0);
    chk("lit_rst_checksum", checksum, 32'd0);
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_class = '0; bus.req_alu = '0;
    bus.req_rd = '0; bus.req_rs1 = '0; bus.req_rs2 = '0; bus.req_imm = '0;
    tick();
    reset_lits();
    tick();
    rst = 1'b1;

    chk("pin_r_sub", model_enc(3'd0, 3'd1, 5'd3, 5'd1, 5'd2, 12'd0), {1'b1, 32'h402081B3});
    chk("pin_i_add", model_enc(3'd1, 3'd0, 5'd1, 5'd0, 5'd0, 12'd5), {1'b1, 32'h00500093});
    chk("pin_lw", model_enc(3'd2, 3'd0, 5'd5, 5'd2, 5'd0, 12'd8), {1'b1, 32'h00812283});
    chk("pin_sw", model_enc(3'd3, 3'd0, 5'd0, 5'd2, 5'd6, 12'd12), {1'b1, 32'h00612623});
    chk("pin_beq", model_enc(3'd4, 3'd0, 5'd0, 5'd1, 5'd2, 12'hFFC), {1'b1, 32'hFE208CE3});
    chk("pin_r_slt", model_enc(3'd0, 3'd5, 5'd4, 5'd5, 5'd6, 12'd0), {1'b1, 32'h0062A233});
    chk("pin_i_sub_illegal", 32'(model_enc(3'd1, 3'd1, 5'd1, 5'd1, 5'd0, 12'd1) >> 32), 32'd0);

    send(3'd0, 3'd1, 5'd3, 5'd1, 5'd2, 12'd0);
    chk("lit_rsub_wdata", bus.imem_wdata, 32'h402081B3);
    chk("lit_rsub_addr", 32'(bus.imem_addr), 32'd0);

    do_flush();
    send(3'd1, 3'd0, 5'd1, 5'd0, 5'd0, 12'd5);
    chk("lit_iadd_wdata", bus.imem_wdata, 32'h00500093);
    send(3'd2, 3'd3, 5'd5, 5'd2, 5'd0, 12'd8);
    chk("lit_lw_wdata", bus.imem_wdata, 32'h00812283);
    chk("lit_lw_addr", 32'(bus.imem_addr), 32'd1);
    chk("lit_count2", 32'(count), 32'd2);

    do_flush();
    send(3'd3, 3'd0, 5'd0, 5'd2, 5'd6, 12'd12);
    chk("lit_sw_wdata", bus.imem_wdata, 32'h00612623);
    send(3'd4, 3'd7, 5'd9, 5'd1, 5'd2, 12'hFFC);
    chk("lit_beq_wdata", bus.imem_wdata, 32'hFE208CE3);
`ifdef ENCODER_CHECKSUM_EN
    chk("lit_checksum", checksum, 32'hFE41AAC0);
`else
    chk("lit_checksum", checksum, 32'h0);
`endif

    do_flush();
    send(3'd1, 3'd1, 5'd1, 5'd1, 5'd0, 12'd1);
    send(3'd7, 3'd0, 5'd1, 5'd1, 5'd0, 12'd1);
    send(3'd0, 3'd4, 5'd1, 5'd1, 5'd2, 12'd0);
    chk("lit_err", 32'(err), 32'd1);
    chk("lit_err_count", 32'(count), 32'd0);

    do_flush();
    chk("lit_flush_err", 32'(err), 32'd0);
    send(3'd1, 3'd3, 5'd2, 5'd1, 5'd0, 12'h7FF);
    send(3'd0, 3'd2, 5'd7, 5'd8, 5'd9, 12'd0);
    send(3'd0, 3'd5, 5'd4, 5'd5, 5'd6, 12'd0);
    chk("lit_rslt_wdata", bus.imem_wdata, 32'h0062A233);
    send(3'd1, 3'd5, 5'd31, 5'd30, 5'd0, 12'h800);
    chk("lit_full", 32'(full), 32'd1);
    chk("lit_full_ready", 32'(bus.req_ready), 32'd0);
    chk("lit_full_count", 32'(count), 32'd4);
    bus.req_class = 3'd1; bus.req_alu = 3'd0; bus.req_valid = 1'b1;
    repeat (5) begin
      tick();
      chk("stall_no_accept", 32'(hs), 32'd0);
    end
    bus.req_valid = 1'b0;
    do_flush();
    chk("lit_flush_full", 32'(full), 32'd0);
    chk("lit_flush_count", 32'(count), 32'd0);
    send(3'd1, 3'd0, 5'd1, 5'd0, 5'd0, 12'd5);
    chk("lit_wrap_addr", 32'(bus.imem_addr), 32'd0);
    chk("lit_wrap_wdata", bus.imem_wdata, 32'h00500093);

    bus.req_class = 3'd0; bus.req_alu = 3'd3; bus.req_rd = 5'd6;
    bus.req_valid = 1'b1;
    begin
      int n;
      n = 0;
      while (!hs && n < 20) begin tick(); n++; end
    end
    bus.req_valid = 1'b0;
    chk("rst_req_accepted", 32'(hs), 32'd1);
    #1 rst = 1'b0;
    #1 reset_lits();
    tick();
    tick();
    rst = 1'b1;
    repeat (3) tick();
    reset_lits();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
